acc_reduce: RTL

- Signed vector accumulator placed directly downstream of the pipelined multiplier. Its inputs are the multiplier's product word and valid pulse.
- Sums a runtime-configured number of products per vector, then applies round-half-up arithmetic right shift and saturation. This provides the mean / sum-of-squares reductions used by the integer layernorm and softmax paths.
- Has no backpressure: accepts a product on every cycle where in_valid is high.

---
 rtl/nn_ops_pkg.sv | 40 ++++
 rtl/rnd_shift_sat.sv | 38 +++
 rtl/acc_reduce.sv | 124 ++++++++++++
 3 files changed

// File: rtl/nn_ops_pkg.sv
// Shared types and arithmetic helpers for the integer reduction / requant datapath.
package nn_ops_pkg;

   localparam int DEF_ACC_WIDTH = 80;
   localparam int DEF_OUT_WIDTH = 32;
   localparam int DEF_LEN_W     = 16;
   localparam int DEF_SH_W      = 6;

   typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;
   typedef logic        [DEF_SH_W-1:0]      sh_t;

   typedef struct packed {
      acc_t sum;
      logic sat;
   } sat_sum_t;

   // Signed add that clips to the accumulator range and reports clipping.
   function automatic sat_sum_t sat_add(input acc_t a, input acc_t b);
      logic [DEF_ACC_WIDTH:0] wide;
      sat_sum_t               r;
      wide  = {a[DEF_ACC_WIDTH-1], a} + {b[DEF_ACC_WIDTH-1], b};
      r.sat = wide[DEF_ACC_WIDTH] ^ wide[DEF_ACC_WIDTH-1];
      if (r.sat) begin
         r.sum = wide[DEF_ACC_WIDTH] ? {1'b1, {(DEF_ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DEF_ACC_WIDTH-1){1'b1}}};
      end else begin
         r.sum = wide[DEF_ACC_WIDTH-1:0];
      end
      return r;
   endfunction

   // Shifts beyond the accumulator's magnitude bits carry no information.
   function automatic sh_t clamp_shift(input sh_t sh);
      if (int'(sh) > DEF_ACC_WIDTH - 1) begin
         return sh_t'(DEF_ACC_WIDTH - 1);
      end
      return sh;
   endfunction

endpackage

// File: rtl/rnd_shift_sat.sv
// Combinational round-half-up arithmetic right shift with saturation to OUT_WIDTH.
module rnd_shift_sat #(
   parameter int ACC_WIDTH = 80,
   parameter int OUT_WIDTH = 32,
   parameter int SH_W      = 6
) (
   input  logic signed [ACC_WIDTH-1:0] din,
   input  logic        [SH_W-1:0]      shift,
   output logic signed [OUT_WIDTH-1:0] dout,
   output logic                        sat
);

   logic signed [ACC_WIDTH:0]             ext;
   logic signed [ACC_WIDTH:0]             bias;
   logic signed [ACC_WIDTH:0]             rnd;
   logic        [ACC_WIDTH-OUT_WIDTH+1:0] hi;

   // Rounding add is one bit wider than the input so the bias can never overflow.
   always_comb begin
      ext  = {din[ACC_WIDTH-1], din};
      bias = '0;
      rnd  = ext;
      if (shift != '0) begin
         bias = (ACC_WIDTH+1)'(1) <<< (shift - 1'b1);
         rnd  = (ext + bias) >>> shift;
      end
      hi = rnd[ACC_WIDTH:OUT_WIDTH-1];
      if ((&hi) || !(|hi)) begin
         sat  = 1'b0;
         dout = rnd[OUT_WIDTH-1:0];
      end else begin
         sat  = 1'b1;
         dout = rnd[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   end

endmodule

// File: rtl/acc_reduce.sv
// Signed vector accumulator: sums cfg_len products, then rounds, shifts and saturates.
module acc_reduce
   import nn_ops_pkg::*;
#(
   parameter int IN_WIDTH  = 64,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int SH_W      = DEF_SH_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic        [LEN_W-1:0]     cfg_len,
   input  logic        [SH_W-1:0]      cfg_shift,
   input  logic                        clr,
   input  logic                        in_valid,
   input  logic signed [IN_WIDTH-1:0]  in_data,
   output logic                        out_valid,
   output logic signed [OUT_WIDTH-1:0] out_data,
   output logic                        out_sat,
   output logic                        busy
);

   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] in_ext;
   logic        [LEN_W-1:0]     cnt;
   logic        [LEN_W-1:0]     len_r;
   logic        [LEN_W-1:0]     eff_len;
   logic        [SH_W-1:0]      shift_r;
   logic        [SH_W-1:0]      eff_shift;
   logic                        sat_r;
   logic                        is_last;
   sat_sum_t                    add_res;

   logic signed [ACC_WIDTH-1:0] fin_r;
   logic        [SH_W-1:0]      fin_shift;
   logic                        fin_v;
   logic                        fin_sat;

   logic signed [OUT_WIDTH-1:0] rs_data;
   logic                        rs_sat;

   // First product of a vector sees the live config; later ones use the latched copy.
   always_comb begin
      in_ext    = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
      add_res   = sat_add(acc, in_ext);
      eff_len   = (cnt == '0) ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_r;
      eff_shift = (cnt == '0) ? clamp_shift(cfg_shift) : shift_r;
      is_last   = ((cnt + 1'b1) == eff_len);
   end

   // Stage 1: accumulate, hand the finished sum and its shift to stage 2.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc       <= '0;
         cnt       <= '0;
         len_r     <= '0;
         shift_r   <= '0;
         sat_r     <= 1'b0;
         fin_r     <= '0;
         fin_shift <= '0;
         fin_v     <= 1'b0;
         fin_sat   <= 1'b0;
      end else if (clr) begin
         acc   <= '0;
         cnt   <= '0;
         sat_r <= 1'b0;
         fin_v <= 1'b0;
      end else if (in_valid) begin
         if (cnt == '0) begin
            len_r   <= eff_len;
            shift_r <= eff_shift;
         end
         if (is_last) begin
            fin_r     <= add_res.sum;
            fin_sat   <= sat_r | add_res.sat;
            fin_shift <= eff_shift;
            fin_v     <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            sat_r     <= 1'b0;
         end else begin
            acc   <= add_res.sum;
            cnt   <= cnt + 1'b1;
            sat_r <= sat_r | add_res.sat;
            fin_v <= 1'b0;
         end
      end else begin
         fin_v <= 1'b0;
      end
   end

   rnd_shift_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SH_W      (SH_W)
   ) u_rnd (
      .din   (fin_r),
      .shift (fin_shift),
      .dout  (rs_data),
      .sat   (rs_sat)
   );

   // Stage 2: register the requantised result; data holds between pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= fin_v;
         if (fin_v) begin
            out_data <= rs_data;
            out_sat  <= fin_sat | rs_sat;
         end
      end
   end

   // A vector is in progress whenever the element counter is non-zero.
   always_comb begin
      busy = (cnt != '0);
   end

endmodule
